// File: rtl/cpu_bus_router_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cpu_bus_router_if : CPU request/completion and target req/ack bus   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
// Signal suffixes are written from the router's point of view.
interface cpu_bus_router_if;
  logic        cpu_req_i;
  logic        cpu_we_i;
  logic [15:0] cpu_addr_i;
  logic [7:0]  cpu_wdata_i;
  logic        cpu_busy_o;
  logic        cpu_done_o;
  logic [7:0]  cpu_rdata_o;
  logic        cpu_err_o;
  logic [3:0]  tgt_sel_o;
  logic        tgt_req_o;
  logic        tgt_we_o;
  logic [15:0] tgt_addr_o;
  logic [7:0]  tgt_wdata_o;
  logic        tgt_ack_i;
  logic [7:0]  tgt_rdata_i;

  // CPU core plus memory/register targets
  modport master (
    output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i, tgt_ack_i, tgt_rdata_i,
    input  cpu_busy_o, cpu_done_o, cpu_rdata_o, cpu_err_o,
           tgt_sel_o, tgt_req_o, tgt_we_o, tgt_addr_o, tgt_wdata_o
  );

  // Router
  modport slave (
    input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i, tgt_ack_i, tgt_rdata_i,
    output cpu_busy_o, cpu_done_o, cpu_rdata_o, cpu_err_o,
           tgt_sel_o, tgt_req_o, tgt_we_o, tgt_addr_o, tgt_wdata_o
  );
endinterface
`default_nettype wire

// File: rtl/cpu_bus_router.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cpu_bus_router : 6502 address decoder and req/ack bus sequencer     |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module cpu_bus_router #(
  parameter int RAM_ADDR_W = 11,
  parameter int PPU_REG_W  = 3,
  parameter bit MIRROR_RAM = 1'b1,
  parameter int TIMEOUT    = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  cpu_bus_router_if.slave  bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam int              CNT_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);
  localparam logic [15:0]     c_RAM_MASK = 16'((32'd1 << RAM_ADDR_W) - 32'd1);
  localparam logic [15:0]     c_PPU_MASK = 16'((32'd1 << PPU_REG_W) - 32'd1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       sel_q, sel_d;
  logic [15:0]      addr_q, addr_d;
  logic             we_q, we_d;
  logic [7:0]       wdata_q, wdata_d;
  logic [7:0]       rdata_q, rdata_d;
  logic             err_q, err_d;
  logic             ok_q, ok_d;
  logic [7:0]       obus_q, obus_d;

  logic [3:0]       w_sel;
  logic [15:0]      w_addr;
  logic             w_ram_fit;

  generate
    if (MIRROR_RAM) begin : g_ram_mirror
      assign w_ram_fit = 1'b1;
    end else begin : g_ram_flat
      assign w_ram_fit = ((bus.cpu_addr_i & 16'h1FFF) & ~c_RAM_MASK) == 16'h0000;
    end
  endgenerate

  // An all-zero select marks an unmapped access.
  always_comb begin
    w_sel  = 4'b0000;
    w_addr = bus.cpu_addr_i;
    if (bus.cpu_addr_i[15:13] == 3'b000) begin
      w_addr = bus.cpu_addr_i & c_RAM_MASK;
      w_sel  = w_ram_fit ? 4'b0001 : 4'b0000;
    end else if (bus.cpu_addr_i[15:13] == 3'b001) begin
      w_addr = 16'h2000 | (bus.cpu_addr_i & c_PPU_MASK);
      w_sel  = 4'b0010;
    end else if (bus.cpu_addr_i[15:5] == 11'h200) begin
      w_sel  = 4'b0100;
    end else begin
      w_sel  = 4'b1000;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    ok_d    = ok_q;
    obus_d  = obus_q;
    case (state_q)
      S_IDLE: begin
        if (bus.cpu_req_i) begin
          sel_d   = w_sel;
          addr_d  = w_addr;
          we_d    = bus.cpu_we_i;
          wdata_d = bus.cpu_wdata_i;
          cnt_d   = '0;
          ok_d    = 1'b0;
          if (w_sel != 4'b0000) begin
            state_d = S_ACCESS;
          end else begin
            state_d = S_DONE;
            rdata_d = obus_q;
          end
        end
      end
      S_ACCESS: begin
        if (bus.tgt_ack_i) begin
          state_d = S_DONE;
          ok_d    = 1'b1;
          rdata_d = we_q ? obus_q : bus.tgt_rdata_i;
        end else if (cnt_q == c_CNT_LAST) begin
          state_d = S_DONE;
          err_d   = 1'b1;
          rdata_d = obus_q;
        end else begin
          cnt_d = cnt_q + c_CNT_ONE;
        end
      end
      S_DONE: begin
        // Open bus follows only completed transfers, committed on the way out.
        state_d = S_IDLE;
        if (ok_q) begin
          obus_d = we_q ? wdata_q : rdata_q;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sel_q   <= 4'b0000;
      addr_q  <= 16'h0000;
      we_q    <= 1'b0;
      wdata_q <= 8'h00;
      rdata_q <= 8'h00;
      err_q   <= 1'b0;
      ok_q    <= 1'b0;
      obus_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      ok_q    <= ok_d;
      obus_q  <= obus_d;
    end
  end

  assign bus.cpu_busy_o  = (state_q != S_IDLE);
  assign bus.cpu_done_o  = (state_q == S_DONE);
  assign bus.cpu_rdata_o = rdata_q;
  assign bus.cpu_err_o   = err_q;
  assign bus.tgt_sel_o   = sel_q;
  assign bus.tgt_req_o   = (state_q == S_ACCESS);
  assign bus.tgt_we_o    = we_q;
  assign bus.tgt_addr_o  = addr_q;
  assign bus.tgt_wdata_o = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_bus_router.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_cpu_bus_router : vector table plus scoreboard bench for router   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_cpu_bus_router;

  localparam int TO_A = 15;
  localparam int TO_B = 3;
  localparam int NVEC = 13;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    int          ack_k;      // ACCESS cycle carrying the ack, 0 = never
    logic [7:0]  ack_data;
    bit          poke;       // raise cpu_req again while busy
    logic [3:0]  exp_sel;
    logic [15:0] exp_addr;
  } vec_t;

  typedef struct {
    int          lat;
    int          reqs;
    logic [7:0]  rdata;
    logic        err;
    logic [3:0]  sel;
    logic [15:0] addr;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  cpu_bus_router_if ifa();
  cpu_bus_router_if ifb();

  cpu_bus_router #(.RAM_ADDR_W(11), .PPU_REG_W(3), .MIRROR_RAM(1'b1), .TIMEOUT(TO_A))
    u_dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
  cpu_bus_router #(.RAM_ADDR_W(11), .PPU_REG_W(3), .MIRROR_RAM(1'b0), .TIMEOUT(TO_B))
    u_dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

  int         checks = 0;
  int         errors = 0;
  logic [7:0] ob_m   = 8'h00;
  exp_t       sb_q[$];
  vec_t       vecs[NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    exp_t e;
    exp_t g;
    int   cyc;
    int   reqs;
    bit   seen;
    bit   busy_ok;
    e.sel  = v.exp_sel;
    e.addr = v.exp_addr;
    e.err  = 1'b0;
    if (v.exp_sel == 4'b0000) begin
      e.lat = 1; e.reqs = 0; e.rdata = ob_m;
    end else if (v.ack_k == 0) begin
      e.lat = TO_A + 1; e.reqs = TO_A; e.err = 1'b1; e.rdata = ob_m;
    end else begin
      e.lat = v.ack_k + 1; e.reqs = v.ack_k;
      e.rdata = v.we ? ob_m : v.ack_data;
      ob_m = v.we ? v.wdata : v.ack_data;
    end

    ifa.cpu_req_i   = 1'b1;
    ifa.cpu_we_i    = v.we;
    ifa.cpu_addr_i  = v.addr;
    ifa.cpu_wdata_i = v.wdata;
    @(posedge clk); #1;
    ifa.cpu_req_i = 1'b0;
    sb_q.push_back(e);
    chk($sformatf("v%0d_sel", idx), 32'(ifa.tgt_sel_o), 32'(v.exp_sel));
    chk($sformatf("v%0d_addr", idx), 32'(ifa.tgt_addr_o), 32'(v.exp_addr));
    chk($sformatf("v%0d_we", idx), 32'(ifa.tgt_we_o), 32'(v.we));
    if (v.we) chk($sformatf("v%0d_wdata", idx), 32'(ifa.tgt_wdata_o), 32'(v.wdata));

    cyc = 1; reqs = 0; seen = 1'b0; busy_ok = 1'b1;
    while (!seen && cyc <= 40) begin
      if (ifa.cpu_done_o) begin
        seen = 1'b1;
      end else begin
        if (ifa.tgt_req_o) reqs++;
        if (!ifa.cpu_busy_o) busy_ok = 1'b0;
        ifa.tgt_ack_i   = (cyc == v.ack_k);
        ifa.tgt_rdata_i = (cyc == v.ack_k) ? v.ack_data : 8'hEE;
        if (v.poke && cyc == 1) begin
          ifa.cpu_req_i  = 1'b1;
          ifa.cpu_addr_i = 16'h2001;
          ifa.cpu_we_i   = ~v.we;
        end
        @(posedge clk); #1;
        ifa.tgt_ack_i = 1'b0;
        ifa.cpu_req_i = 1'b0;
        cyc++;
      end
    end

    g = sb_q.pop_front();
    if (!seen) begin
      checks++; errors++;
      $display("FAIL v%0d_done: got no cpu_done, expected one within 40 cycles", idx);
    end else begin
      chk($sformatf("v%0d_lat", idx), 32'(cyc), 32'(g.lat));
      chk($sformatf("v%0d_reqs", idx), 32'(reqs), 32'(g.reqs));
      chk($sformatf("v%0d_rdata", idx), 32'(ifa.cpu_rdata_o), 32'(g.rdata));
      chk($sformatf("v%0d_err", idx), 32'(ifa.cpu_err_o), 32'(g.err));
      chk($sformatf("v%0d_busy_thru", idx), 32'(busy_ok & ifa.cpu_busy_o), 32'd1);
      chk($sformatf("v%0d_hold", idx), {12'h0, ifa.tgt_sel_o, ifa.tgt_addr_o}, {12'h0, g.sel, g.addr});
      @(posedge clk); #1;
      chk($sformatf("v%0d_idle", idx), {30'h0, ifa.cpu_busy_o, ifa.cpu_done_o}, 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //          we    addr      wdata  k   ackd   poke  sel      taddr
    vecs[0]  = '{1'b0, 16'h1801, 8'h00, 1,  8'h5A, 1'b0, 4'b0001, 16'h0001};
    vecs[1]  = '{1'b1, 16'h3FFE, 8'h80, 1,  8'h00, 1'b0, 4'b0010, 16'h2006};
    vecs[2]  = '{1'b0, 16'h4017, 8'h00, 0,  8'h00, 1'b0, 4'b0100, 16'h4017};
    vecs[3]  = '{1'b0, 16'h4016, 8'h00, 3,  8'h11, 1'b1, 4'b0100, 16'h4016};
    vecs[4]  = '{1'b0, 16'h8000, 8'h00, 3,  8'hC3, 1'b0, 4'b1000, 16'h8000};
    vecs[5]  = '{1'b0, 16'h401F, 8'h00, 2,  8'h22, 1'b0, 4'b0100, 16'h401F};
    vecs[6]  = '{1'b0, 16'h4020, 8'h00, 1,  8'h33, 1'b0, 4'b1000, 16'h4020};
    vecs[7]  = '{1'b1, 16'h0000, 8'h7E, 2,  8'h00, 1'b1, 4'b0001, 16'h0000};
    vecs[8]  = '{1'b0, 16'h1FFF, 8'h00, 1,  8'h44, 1'b0, 4'b0001, 16'h07FF};
    vecs[9]  = '{1'b0, 16'h2000, 8'h00, 1,  8'h55, 1'b0, 4'b0010, 16'h2000};
    vecs[10] = '{1'b1, 16'hFFFF, 8'h99, 0,  8'h00, 1'b0, 4'b1000, 16'hFFFF};
    vecs[11] = '{1'b0, 16'hC000, 8'h00, 15, 8'h66, 1'b0, 4'b1000, 16'hC000};
    vecs[12] = '{1'b0, 16'h2FF9, 8'h00, 2,  8'h01, 1'b0, 4'b0010, 16'h2001};

    ifa.cpu_req_i = 1'b0; ifa.cpu_we_i = 1'b0; ifa.cpu_addr_i = 16'h0; ifa.cpu_wdata_i = 8'h0;
    ifa.tgt_ack_i = 1'b0; ifa.tgt_rdata_i = 8'h0;
    ifb.cpu_req_i = 1'b0; ifb.cpu_we_i = 1'b0; ifb.cpu_addr_i = 16'h0; ifb.cpu_wdata_i = 8'h0;
    ifb.tgt_ack_i = 1'b0; ifb.tgt_rdata_i = 8'h0;

    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a_ctrl", {ifa.cpu_busy_o, ifa.cpu_done_o, ifa.cpu_err_o, ifa.tgt_req_o, ifa.tgt_we_o}, 32'd0);
    chk("rst_a_data", {ifa.cpu_rdata_o, ifa.tgt_wdata_o, ifa.tgt_addr_o}, 32'd0);
    chk("rst_a_sel", 32'(ifa.tgt_sel_o), 32'd0);
    chk("rst_b_ctrl", {ifb.cpu_busy_o, ifb.cpu_done_o, ifb.tgt_req_o, ifb.tgt_sel_o}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // ack while idle must not start anything
    ifa.tgt_ack_i = 1'b1; ifa.tgt_rdata_i = 8'hA5;
    @(posedge clk); #1;
    ifa.tgt_ack_i = 1'b0;
    chk("idle_ack", {30'h0, ifa.cpu_busy_o, ifa.cpu_done_o}, 32'd0);

    for (int i = 0; i < NVEC; i++) run_vec(vecs[i], i);

    // reset in the middle of an access
    ifa.cpu_req_i = 1'b1; ifa.cpu_we_i = 1'b0; ifa.cpu_addr_i = 16'h8000;
    @(posedge clk); #1;
    ifa.cpu_req_i = 1'b0;
    @(posedge clk); #1;
    chk("mid_req_before", 32'(ifa.tgt_req_o), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_now", {30'h0, ifa.tgt_req_o, ifa.cpu_busy_o}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk($sformatf("mid_rst_nodone%0d", i), 32'(ifa.cpu_done_o), 32'd0);
    end
    @(negedge clk) rst_n = 1'b1;
    ob_m = 8'h00;
    @(posedge clk); #1;
    chk("mid_rst_addr", 32'(ifa.tgt_addr_o), 32'd0);
    run_vec('{1'b0, 16'h0123, 8'h00, 1, 8'h3C, 1'b0, 4'b0001, 16'h0123}, 90);

    // non-mirrored RAM instance: unmapped reads return open bus
    ifb.cpu_req_i = 1'b1; ifb.cpu_we_i = 1'b0; ifb.cpu_addr_i = 16'h0800;
    @(posedge clk); #1;
    ifb.cpu_req_i = 1'b0;
    chk("b_unm_done", {ifb.cpu_done_o, ifb.tgt_req_o, ifb.cpu_err_o}, 32'b100);
    chk("b_unm_sel", 32'(ifb.tgt_sel_o), 32'd0);
    chk("b_unm_rdata", 32'(ifb.cpu_rdata_o), 32'h00);
    @(posedge clk); #1;
    ifb.cpu_req_i = 1'b1; ifb.cpu_we_i = 1'b1; ifb.cpu_addr_i = 16'h07FF; ifb.cpu_wdata_i = 8'hAB;
    @(posedge clk); #1;
    ifb.cpu_req_i = 1'b0;
    chk("b_wr_sel", {ifb.tgt_req_o, ifb.tgt_sel_o, ifb.tgt_addr_o}, {11'h0, 1'b1, 4'b0001, 16'h07FF});
    ifb.tgt_ack_i = 1'b1;
    @(posedge clk); #1;
    ifb.tgt_ack_i = 1'b0;
    chk("b_wr_done", {30'h0, ifb.cpu_done_o, ifb.cpu_err_o}, 32'b10);
    @(posedge clk); #1;
    ifb.cpu_req_i = 1'b1; ifb.cpu_we_i = 1'b0; ifb.cpu_addr_i = 16'h1000;
    @(posedge clk); #1;
    ifb.cpu_req_i = 1'b0;
    chk("b_unm2_done", {ifb.cpu_done_o, ifb.tgt_req_o, ifb.tgt_sel_o}, 32'b1_0_0000 << 0);
    chk("b_unm2_rdata", 32'(ifb.cpu_rdata_o), 32'hAB);
    @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
